dram_access_ctrl: RTL
=====================

Name: dram_access_ctrl

Overview:
- Initiator-side controller that drives the word-only data DRAM port (`adr`, `we`, `wdin`, `rdo`) on behalf of the CPU load/store path.
- Accepts byte, halfword and word load/store requests through a valid/ready handshake.
- Performs sub-word stores as a read-modify-write, and sign- or zero-extends sub-word loads.
- Returns the result on a held response channel.

Parameters:
ADDR_W, 16, width of DRAM byte address driven on dram_adr
RESET_ADDR, 16'h0000, value of dram_adr while idle and after reset

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller can accept a request (high only in IDLE)
req_we  in  1  1 = store, 0 = load
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as error)
req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  response available
resp_ready  in  1  consumer takes response
resp_rdata  out  32  load result (extended); 0 for stores and errors
resp_err  out  1  misaligned, reserved size, or out-of-range (see Optional Feature)
dram_adr  out  ADDR_W  DRAM byte address (DRAM uses [13:2])
dram_we  out  1  DRAM write enable
dram_wdin  out  32  DRAM write data
dram_rdo  in  32  DRAM asynchronous read data

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; dram_we=0; dram_adr=RESET_ADDR; dram_wdin=0.
- dram_we is decoded from the state register only (high only in WRITE), so it never glitches.
- States:
  - IDLE, LOAD, RMW_RD, WRITE, RESP.
- Acceptance and latching:
  - Handshake completes on req_valid && req_ready.
  - On acceptance, latch addr, size, we, unsigned and wdata.
  - Request inputs are ignored in every other state.
- Error check at acceptance:
  - Half access with addr[0]=1 is an error.
  - Word access with addr[1:0]!=0 is an error.
  - size=3 is an error.
  - On error: go to RESP with resp_err=1 and resp_rdata=0. No DRAM access is made and dram_we stays 0.
- Load path:
  - IDLE->LOAD. In LOAD, dram_adr = latched addr[ADDR_W-1:0].
  - Lane select, little-endian:
    - byte: rdo >> (8*addr[1:0])
    - half: rdo >> (16*addr[1])
  - Extend per req_unsigned.
  - The extended value is registered into resp_rdata at the end of LOAD; state goes to RESP.
  - Latency: resp_valid is high 2 cycles after the accept edge.
- Word store:
  - IDLE->WRITE. dram_wdin = wdata, dram_we=1 for exactly one cycle, then RESP.
- Sub-word store:
  - IDLE->RMW_RD. Capture dram_rdo into a merge register.
  - RMW_RD->WRITE. dram_wdin = merge word with only the addressed byte or half replaced by wdata[7:0] or wdata[15:0]; dram_we=1 for one cycle.
  - Then RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - On that handshake, return to IDLE.
  - A resp_ready that is high on entry to RESP completes in that same cycle.
  - No back-to-back acceptance: req_ready rises the cycle after the response handshake.
- dram_adr holds the last latched address outside LOAD, RMW_RD and WRITE (RESET_ADDR until the first access).
- Reset mid-operation:
  - rst in any state forces IDLE at that edge.
  - A WRITE state coinciding with rst still writes on that edge, because the DRAM samples we at the same edge.
  - No further writes occur after reset, and any pending response is discarded.
- Upper address bits [31:ADDR_W] are ignored unless MAU_OOR_CHECK_EN is defined.

Optional Feature:
- Macro: MAU_OOR_CHECK_EN.
- Defined: a request with req_addr[31:ADDR_W] != 0 is flagged at acceptance as an error. It follows the error path: RESP, resp_err=1, no DRAM access.
- Undefined: upper bits are ignored, addresses alias modulo 2^ADDR_W, and no out-of-range error is produced.

Test Plan:
- Word store addr=0x0010, wdata=0xDEADBEEF, then word load addr=0x0010 -> exactly one dram_we pulse at adr 0x0010; load resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after accept.
- Mem word 0x0020 = 0x11223344; byte store addr=0x0021 wdata=0xAB -> RMW read, then write 0x1122AB44; DRAM written once.
- Mem word 0x0030 = 0x80FF7F01; loads:
  - signed byte @0x0032 -> 0xFFFFFFFF
  - unsigned byte @0x0032 -> 0x000000FF
  - signed half @0x0032 -> 0xFFFF80FF
  - signed byte @0x0031 -> 0x0000007F
- Misaligned word load addr=0x0006 and half store addr=0x0003 -> resp_err=1, resp_rdata=0, dram_we never asserted, resp_valid 1 cycle after accept.
- Hold resp_ready=0 for 5 cycles after load completes -> resp_valid and resp_rdata stable and req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- Assert rst during RMW_RD of a half store -> next cycle IDLE, req_ready=1, resp_valid=0, target word unchanged. With MAU_OOR_CHECK_EN, word load addr=0x00010000 -> resp_err=1; without it, that load returns mem word 0x0000.

Source files
------------

// File: rtl/dram_access_ctrl_if.sv
// CPU-side load/store request and held response channel
// of dram_access_ctrl.
interface dram_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned,
        output req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned,
        input  req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dram_access_ctrl.sv
// Byte/half/word load-store controller for a word-only DRAM port.
// Define MAU_OOR_CHECK_EN to flag addresses beyond ADDR_W as errors.
module dram_access_ctrl #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    dram_access_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] dram_adr,
    output logic              dram_we,
    output logic [31:0]       dram_wdin,
    input  logic [31:0]       dram_rdo
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_WRITE,
        S_RESP
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       merge_q, merge_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_ready;
    logic              resp_valid;
    logic              acc_err;
    logic              oor;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [31:0]       ld_ext;
    logic [4:0]        bsh;
    logic [4:0]        hsh;
    logic [31:0]       mask;
    logic [31:0]       ins;
    logic [31:0]       merged;

`ifdef MAU_OOR_CHECK_EN
    assign oor = (bus.req_addr >> ADDR_W) != 32'd0;
`else
    logic oor_unused;
    assign oor_unused = |(bus.req_addr >> ADDR_W);
    assign oor        = 1'b0;
`endif

    always_comb begin
        acc_err = oor;
        unique case (bus.req_size)
            2'd0:    acc_err = oor;
            2'd1:    acc_err = oor | bus.req_addr[0];
            2'd2:    acc_err = oor | (bus.req_addr[1:0] != 2'b00);
            default: acc_err = 1'b1;
        endcase
    end

    // Little-endian lane select from the word the DRAM is presenting
    always_comb begin
        ld_byte = dram_rdo[7:0];
        unique case (adr_q[1:0])
            2'd0:    ld_byte = dram_rdo[7:0];
            2'd1:    ld_byte = dram_rdo[15:8];
            2'd2:    ld_byte = dram_rdo[23:16];
            default: ld_byte = dram_rdo[31:24];
        endcase
        ld_half = adr_q[1] ? dram_rdo[31:16] : dram_rdo[15:0];
        unique case (size_q)
            2'd0: ld_ext = uns_q ? {24'h0, ld_byte}
                                 : {{24{ld_byte[7]}}, ld_byte};
            2'd1: ld_ext = uns_q ? {16'h0, ld_half}
                                 : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = dram_rdo;
        endcase
    end

    always_comb begin
        bsh = {adr_q[1:0], 3'b000};
        hsh = {adr_q[1], 4'b0000};
        if (size_q == 2'd0) begin
            mask = 32'h0000_00ff << bsh;
            ins  = {24'h0, wdata_q[7:0]} << bsh;
        end else begin
            mask = 32'h0000_ffff << hsh;
            ins  = {16'h0, wdata_q[15:0]} << hsh;
        end
        merged = (merge_q & ~mask) | (ins & mask);
    end

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        size_d     = size_q;
        we_d       = we_q;
        uns_d      = uns_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        dram_we    = 1'b0;
        dram_wdin  = 32'h0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    adr_d   = bus.req_addr[ADDR_W-1:0];
                    size_d  = bus.req_size;
                    we_d    = bus.req_we;
                    uns_d   = bus.req_unsigned;
                    wdata_d = bus.req_wdata;
                    rdata_d = 32'h0;
                    err_d   = acc_err;
                    if (acc_err)
                        state_d = S_RESP;
                    else if (!bus.req_we)
                        state_d = S_LOAD;
                    else if (bus.req_size == 2'd2)
                        state_d = S_WRITE;
                    else
                        state_d = S_RMW_RD;
                end
            end
            S_LOAD: begin
                rdata_d = ld_ext;
                state_d = S_RESP;
            end
            S_RMW_RD: begin
                merge_d = dram_rdo;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                dram_we   = 1'b1;
                dram_wdin = (size_q == 2'd2) ? wdata_q : merged;
                state_d   = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (bus.resp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            adr_q   <= RESET_ADDR;
            size_q  <= 2'd0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            merge_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            merge_q <= merge_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    logic we_unused;
    assign we_unused = we_q;

    assign dram_adr       = adr_q;
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = resp_valid;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

endmodule
